// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, types and helpers for the pipeline register chain
//
// Purpose: one place for the pipeline depth limit, the control-bit layout that
// every stage uses to pack its control bundle, the per-cell operation code and a
// small popcount helper.
// Ports: none (package).

package pipe_pkg;

  localparam int MAX_PIPE_DEPTH = 4;

  // Bit positions inside the control bundle; every stage packs InCtrl this way.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_HIWRITE  = 2;
  localparam int CTRL_LOWRITE  = 3;
  localparam int CTRL_LINK     = 4;
  localparam int CTRL_HISRC    = 5;
  localparam int CTRL_LOSRC    = 6;

  // What a single stage cell does on the next rising edge.
  typedef enum logic [1:0] {
    CELL_HOLD    = 2'd0,
    CELL_CLEAR   = 2'd1,
    CELL_CAPTURE = 2'd2
  } cellOp_e;

  // Number of set bits in a valid vector of up to MAX_PIPE_DEPTH stages.
  function automatic logic [2:0] countOnes(input logic [MAX_PIPE_DEPTH-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_PIPE_DEPTH; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// rtl/pipe_stage_cell.sv - one valid/ctrl/data register set with hold, clear and capture
//
// Purpose: a single pipeline stage. On capture, the control bundle is forced to
// zero when the incoming entry is not valid, so a bubble always reads as a no-op.
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset, clears everything
//   Op        hold / clear / capture for this edge
//   InValid   valid bit from the previous stage (or chain input)
//   InCtrl    control bundle from the previous stage
//   InData    data bundle from the previous stage
//   OutValid  registered valid bit
//   OutCtrl   registered control bundle (zero whenever OutValid = 0)
//   OutData   registered data bundle

module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 197
) (
  input  logic              Clk,
  input  logic              Rst,
  input  cellOp_e           Op,
  input  logic              InValid,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [DATA_W-1:0] OutData
);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      OutValid <= 1'b0;
      OutCtrl  <= '0;
      OutData  <= '0;
    end else begin
      case (Op)
        CELL_CLEAR: begin
          OutValid <= 1'b0;
          OutCtrl  <= '0;
          OutData  <= '0;
        end
        CELL_CAPTURE: begin
          OutValid <= InValid;
          OutCtrl  <= InValid ? InCtrl : '0;
          OutData  <= InData;
        end
        default: begin
          OutValid <= OutValid;
          OutCtrl  <= OutCtrl;
          OutData  <= OutData;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised pipeline register chain with stall, flush and stall accounting
//
// Purpose: DEPTH stage cells in series carrying a control and a data bundle, plus
// a registered occupancy count and a saturating stall-cycle counter.
// Per-edge priority: Rst > Flush > Stall > advance.
// Ports:
//   Clk, Rst      clock and synchronous active-high reset
//   InValid       entry presented this cycle is a real instruction
//   InCtrl        control bundle from upstream
//   InData        data bundle from upstream
//   Stall         hold every stage, input not captured
//   Flush         kill every stage, input dropped
//   OutValid      last stage holds a real instruction
//   OutCtrl       last stage control bundle, zero on a bubble
//   OutData       last stage data bundle
//   Occupancy     number of valid stages
//   StallCycles   saturating count of accepted stall cycles

module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 197,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         InValid,
  input  logic [CTRL_W-1:0]            InCtrl,
  input  logic [DATA_W-1:0]            InData,
  input  logic                         Stall,
  input  logic                         Flush,
  output logic                         OutValid,
  output logic [CTRL_W-1:0]            OutCtrl,
  output logic [DATA_W-1:0]            OutData,
  output logic [$clog2(DEPTH+1)-1:0]   Occupancy,
  output logic [CNT_W-1:0]             StallCycles
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : gBadDepth
    $error("pipe_stage_chain: DEPTH must be in 1..%0d", MAX_PIPE_DEPTH);
  end

  // Index 0 is the chain input; index i+1 is the output of cell i.
  logic [DEPTH:0]    chainValid;
  logic [CTRL_W-1:0] chainCtrl [0:DEPTH];
  logic [DATA_W-1:0] chainData [0:DEPTH];
  logic [DEPTH-1:0]  nextValid;
  cellOp_e           cellOp;

  assign chainValid[0] = InValid;
  assign chainCtrl[0]  = InCtrl;
  assign chainData[0]  = InData;

  always_comb begin
    cellOp = CELL_CAPTURE;
    if (Flush) begin
      cellOp = CELL_CLEAR;
    end else if (Stall) begin
      cellOp = CELL_HOLD;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    pipe_stage_cell #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) uCell (
      .Clk      (Clk),
      .Rst      (Rst),
      .Op       (cellOp),
      .InValid  (chainValid[i]),
      .InCtrl   (chainCtrl[i]),
      .InData   (chainData[i]),
      .OutValid (chainValid[i+1]),
      .OutCtrl  (chainCtrl[i+1]),
      .OutData  (chainData[i+1])
    );
  end

  // Outputs come straight from the last cell's flops.
  assign OutValid = chainValid[DEPTH];
  assign OutCtrl  = chainCtrl[DEPTH];
  assign OutData  = chainData[DEPTH];

  // Valid bits the cells will hold after this edge, so Occupancy can be
  // registered on the same edge instead of trailing the stages by one cycle.
  always_comb begin
    nextValid = '0;
    if (!Flush) begin
      if (Stall) begin
        nextValid = chainValid[DEPTH:1];
      end else begin
        nextValid = chainValid[DEPTH-1:0];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Occupancy <= '0;
    end else begin
      Occupancy <= OCC_W'(countOnes(MAX_PIPE_DEPTH'(nextValid)));
    end
  end

  // Flush outranks Stall, so a flushed cycle never counts as a stall.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCycles <= '0;
    end else if (!Flush && Stall && (StallCycles != {CNT_W{1'b1}})) begin
      StallCycles <= StallCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - self-checking bench for pipe_stage_chain at depths 3, 2 and 1

module tb_pipe_stage_chain;

  localparam int CW = 12;
  localparam int DW = 197;

  logic          Clk = 1'b0;
  logic          Rst, InValid, Stall, Flush;
  logic [CW-1:0] InCtrl;
  logic [DW-1:0] InData;

  logic          v3, v2, v1;
  logic [CW-1:0] c3, c2, c1;
  logic [DW-1:0] d3, d2, d1;
  logic [1:0]    o3, o2;
  logic [0:0]    o1;
  logic [15:0]   s3, s2;
  logic [3:0]    s1;

  int nAssert = 0;
  int nFail   = 0;

  always #5 Clk = ~Clk;

  pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .CNT_W(16)) u3 (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InCtrl(InCtrl), .InData(InData),
    .Stall(Stall), .Flush(Flush), .OutValid(v3), .OutCtrl(c3), .OutData(d3),
    .Occupancy(o3), .StallCycles(s3));

  pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CNT_W(16)) u2 (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InCtrl(InCtrl), .InData(InData),
    .Stall(Stall), .Flush(Flush), .OutValid(v2), .OutCtrl(c2), .OutData(d2),
    .Occupancy(o2), .StallCycles(s2));

  pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CNT_W(4)) u1 (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InCtrl(InCtrl), .InData(InData),
    .Stall(Stall), .Flush(Flush), .OutValid(v1), .OutCtrl(c1), .OutData(d1),
    .Occupancy(o1), .StallCycles(s1));

  // Reference: each instance is a FIFO-like line of entries; index 0 is newest.
  int            depth [3] = '{3, 2, 1};
  int            cmax  [3] = '{65535, 65535, 15};
  logic          mV [3][4];
  logic [CW-1:0] mC [3][4];
  logic [DW-1:0] mD [3][4];
  int            mCnt [3];

  function automatic logic [DW-1:0] rndData();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction

  function automatic int occ(input int i);
    int n = 0;
    for (int s = 0; s < depth[i]; s++) n += int'(mV[i][s]);
    return n;
  endfunction

  task automatic modelEdge();
    for (int i = 0; i < 3; i++) begin
      if (Rst || Flush) begin
        for (int s = 0; s < 4; s++) begin
          mV[i][s] = 1'b0; mC[i][s] = '0; mD[i][s] = '0;
        end
        if (Rst) mCnt[i] = 0;
      end else if (Stall) begin
        if (mCnt[i] < cmax[i]) mCnt[i]++;
      end else begin
        for (int s = 3; s > 0; s--) begin
          mV[i][s] = mV[i][s-1]; mC[i][s] = mC[i][s-1]; mD[i][s] = mD[i][s-1];
        end
        mV[i][0] = InValid;
        mC[i][0] = InValid ? InCtrl : '0;
        mD[i][0] = InData;
      end
    end
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    check("u3.valid", 256'(v3), 256'(mV[0][2]));
    check("u3.ctrl",  256'(c3), 256'(mC[0][2]));
    check("u3.data",  256'(d3), 256'(mD[0][2]));
    check("u3.occ",   256'(o3), 256'(occ(0)));
    check("u3.stall", 256'(s3), 256'(mCnt[0]));
    check("u2.valid", 256'(v2), 256'(mV[1][1]));
    check("u2.ctrl",  256'(c2), 256'(mC[1][1]));
    check("u2.data",  256'(d2), 256'(mD[1][1]));
    check("u2.occ",   256'(o2), 256'(occ(1)));
    check("u2.stall", 256'(s2), 256'(mCnt[1]));
    check("u1.valid", 256'(v1), 256'(mV[2][0]));
    check("u1.ctrl",  256'(c1), 256'(mC[2][0]));
    check("u1.data",  256'(d1), 256'(mD[2][0]));
    check("u1.occ",   256'(o1), 256'(occ(2)));
    check("u1.stall", 256'(s1), 256'(mCnt[2]));
  endtask

  // Apply inputs, take one rising edge, then compare on the falling edge.
  task automatic step(input logic r, input logic f, input logic st,
                      input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    Rst = r; Flush = f; Stall = st; InValid = v; InCtrl = c; InData = d;
    @(posedge Clk);
    modelEdge();
    @(negedge Clk);
    checkAll();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mCnt[i] = 0;
      for (int s = 0; s < 4; s++) begin
        mV[i][s] = 1'b0; mC[i][s] = '0; mD[i][s] = '0;
      end
    end
    Rst = 1'b1; Flush = 1'b0; Stall = 1'b0; InValid = 1'b1; InCtrl = 12'hFFF; InData = '1;
    @(negedge Clk);

    // Reset held two cycles while a valid entry is presented.
    step(1, 0, 0, 1, 12'hFFF, rndData());
    step(1, 0, 0, 1, 12'hFFF, rndData());
    check("rst.u3.valid", 256'(v3), 256'(0));
    check("rst.u3.ctrl",  256'(c3), 256'(0));
    check("rst.u3.data",  256'(d3), 256'(0));
    check("rst.u3.occ",   256'(o3), 256'(0));
    check("rst.u3.stall", 256'(s3), 256'(0));

    // Pass-through on the depth-3 chain: tags 1,2,3.
    step(0, 0, 0, 1, 12'h0A5, 197'd1);
    check("pass.occ1", 256'(o3), 256'(1));
    step(0, 0, 0, 1, 12'h0A5, 197'd2);
    check("pass.occ2", 256'(o3), 256'(2));
    check("pass.notyet", 256'(v3), 256'(0));
    step(0, 0, 0, 1, 12'h0A5, 197'd3);
    check("pass.occ3", 256'(o3), 256'(3));
    check("pass.tag1", 256'(d3), 256'(1));
    check("pass.ctrl1", 256'(c3), 256'(12'h0A5));
    step(0, 0, 0, 0, 12'h000, 197'd0);
    check("pass.tag2", 256'(d3), 256'(2));
    step(0, 0, 0, 0, 12'h000, 197'd0);
    check("pass.tag3", 256'(d3), 256'(3));

    // Bubble on the depth-1 chain keeps data but zeroes control.
    step(0, 0, 0, 0, 12'hFFF, 197'h1234);
    check("bub.valid", 256'(v1), 256'(0));
    check("bub.ctrl",  256'(c1), 256'(0));
    check("bub.data",  256'(d1), 256'(197'h1234));

    // Stall on the depth-2 chain: tag 6 at the output, tag 5 behind it.
    step(0, 1, 0, 0, 12'h000, 197'd0);
    step(0, 0, 0, 1, 12'h011, 197'd6);
    step(0, 0, 0, 1, 12'h022, 197'd5);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 1, CW'($urandom), rndData());
      check("stall.hold6", 256'(d2), 256'(6));
    end
    check("stall.count4", 256'(s2), 256'(4));
    step(0, 0, 0, 1, 12'h033, 197'd7);
    check("stall.tag5", 256'(d2), 256'(5));
    check("stall.occ2", 256'(o2), 256'(2));

    // Flush together with Stall and a valid input: chain empties, count unchanged.
    step(0, 1, 1, 1, 12'hFFF, rndData());
    check("flush.occ",   256'(o2), 256'(0));
    check("flush.ctrl",  256'(c2), 256'(0));
    check("flush.stall", 256'(s2), 256'(4));

    // Saturation of the 4-bit counter.
    for (int k = 0; k < 20; k++) step(0, 0, 1, 1, CW'($urandom), rndData());
    check("sat.u1", 256'(s1), 256'(15));
    check("sat.u2", 256'(s2), 256'(24));

    // Randomised traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom), CW'($urandom), rndData());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
